// File: rtl/mem_fill_arbiter_if.sv
// Cache request/fill signals and main-memory bus shared by mem_fill_arbiter and its environment.
// slave = arbiter side, master = caches plus memory model side.
interface mem_fill_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int OFF_W  = 3
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_wr_req;
  logic [ADDR_W-1:0] d_wr_addr;
  logic [15:0]       d_wr_data;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              mem_valid;
  logic [15:0]       fill_data;
  logic [OFF_W-1:0]  fill_offset;
  logic              i_fill_we;
  logic              d_fill_we;
  logic              i_done;
  logic              d_done;
  logic              d_wr_ack;
  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_wr_req, d_wr_addr, d_wr_data,
           mem_rdata, mem_valid,
    output mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_offset,
           i_fill_we, d_fill_we, i_done, d_done, d_wr_ack, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, d_wr_req, d_wr_addr, d_wr_data,
           mem_rdata, mem_valid,
    input  mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_offset,
           i_fill_we, d_fill_we, i_done, d_done, d_wr_ack, busy
  );
endinterface

// File: rtl/mem_fill_arbiter.sv
// Arbitrates icache fill, dcache fill and dcache write-through onto one pipelined memory.
// Optional critical-word-first fill ordering is enabled by defining CRIT_WORD_FIRST_EN.
module mem_fill_arbiter #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16
) (
  input logic               clk,
  input logic               rst,
  mem_fill_arbiter_if.slave bus
);
  localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
  localparam logic [OFF_W:0]    CNT_FULL = (OFF_W+1)'(WORDS_PER_BLOCK);
  localparam logic [OFF_W:0]    CNT_LAST = (OFF_W+1)'(WORDS_PER_BLOCK - 1);
  localparam logic [OFF_W:0]    CNT_ONE  = (OFF_W+1)'(1);
  localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(2 * WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {IDLE, WRITE, FILL_I, FILL_D} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base, base_nxt;
  logic [15:0]       wdata, wdata_nxt;
  logic [OFF_W-1:0]  start, start_nxt;
  logic [OFF_W:0]    issue_cnt, issue_cnt_nxt;
  logic [OFF_W:0]    ret_cnt, ret_cnt_nxt;
  logic [15:0]       fill_data_nxt;
  logic [OFF_W-1:0]  fill_offset_nxt;
  logic              i_fill_we_nxt, d_fill_we_nxt, i_done_nxt, d_done_nxt;
  logic              filling, issuing, i_pend, d_pend;
  logic [OFF_W-1:0]  issue_off;

  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] a);
    return a & ~BLK_MASK;
  endfunction

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] b,
                                                  input logic [OFF_W-1:0]  off);
    return b | {{(ADDR_W-OFF_W-1){1'b0}}, off, 1'b0};
  endfunction

  assign filling   = (state == FILL_I) || (state == FILL_D);
  assign issuing   = filling && (issue_cnt != CNT_FULL);
  assign issue_off = start + issue_cnt[OFF_W-1:0];
  // A requester still sees its own done pulse this cycle; do not re-grant it.
  assign i_pend    = bus.i_req && !bus.i_done;
  assign d_pend    = bus.d_req && !bus.d_done;

  assign bus.mem_en    = issuing || (state == WRITE);
  assign bus.mem_wr    = (state == WRITE);
  assign bus.mem_addr  = (state == WRITE) ? base :
                         (issuing ? word_addr(base, issue_off) : {ADDR_W{1'b0}});
  assign bus.mem_wdata = (state == WRITE) ? wdata : 16'h0000;
  assign bus.d_wr_ack  = (state == WRITE);
  assign bus.busy      = (state != IDLE);

  // Next-state, arbitration and fill-return decode.
  always_comb begin
    state_nxt       = state;
    base_nxt        = base;
    wdata_nxt       = wdata;
    start_nxt       = start;
    issue_cnt_nxt   = issue_cnt;
    ret_cnt_nxt     = ret_cnt;
    fill_data_nxt   = bus.fill_data;
    fill_offset_nxt = bus.fill_offset;
    i_fill_we_nxt   = 1'b0;
    d_fill_we_nxt   = 1'b0;
    i_done_nxt      = 1'b0;
    d_done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.d_wr_req) begin
          state_nxt = WRITE;
          base_nxt  = bus.d_wr_addr;
          wdata_nxt = bus.d_wr_data;
        end else if (d_pend) begin
          state_nxt     = FILL_D;
          base_nxt      = block_base(bus.d_addr);
`ifdef CRIT_WORD_FIRST_EN
          start_nxt     = bus.d_addr[OFF_W:1];
`else
          start_nxt     = {OFF_W{1'b0}};
`endif
          issue_cnt_nxt = {(OFF_W+1){1'b0}};
          ret_cnt_nxt   = {(OFF_W+1){1'b0}};
        end else if (i_pend) begin
          state_nxt     = FILL_I;
          base_nxt      = block_base(bus.i_addr);
`ifdef CRIT_WORD_FIRST_EN
          start_nxt     = bus.i_addr[OFF_W:1];
`else
          start_nxt     = {OFF_W{1'b0}};
`endif
          issue_cnt_nxt = {(OFF_W+1){1'b0}};
          ret_cnt_nxt   = {(OFF_W+1){1'b0}};
        end else begin
          state_nxt = IDLE;
        end
      end
      WRITE: begin
        state_nxt = IDLE;
      end
      FILL_I, FILL_D: begin
        if (issuing) begin
          issue_cnt_nxt = issue_cnt + CNT_ONE;
        end else begin
          issue_cnt_nxt = issue_cnt;
        end
        if (bus.mem_valid && (ret_cnt != CNT_FULL)) begin
          fill_data_nxt   = bus.mem_rdata;
          fill_offset_nxt = start + ret_cnt[OFF_W-1:0];
          ret_cnt_nxt     = ret_cnt + CNT_ONE;
          i_fill_we_nxt   = (state == FILL_I);
          d_fill_we_nxt   = (state == FILL_D);
          if (ret_cnt == CNT_LAST) begin
            state_nxt  = IDLE;
            i_done_nxt = (state == FILL_I);
            d_done_nxt = (state == FILL_D);
          end else begin
            state_nxt  = state;
          end
        end else begin
          ret_cnt_nxt = ret_cnt;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, burst bookkeeping and registered fill outputs; reset aborts any fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      base            <= {ADDR_W{1'b0}};
      wdata           <= 16'h0000;
      start           <= {OFF_W{1'b0}};
      issue_cnt       <= {(OFF_W+1){1'b0}};
      ret_cnt         <= {(OFF_W+1){1'b0}};
      bus.fill_data   <= 16'h0000;
      bus.fill_offset <= {OFF_W{1'b0}};
      bus.i_fill_we   <= 1'b0;
      bus.d_fill_we   <= 1'b0;
      bus.i_done      <= 1'b0;
      bus.d_done      <= 1'b0;
    end else begin
      state           <= state_nxt;
      base            <= base_nxt;
      wdata           <= wdata_nxt;
      start           <= start_nxt;
      issue_cnt       <= issue_cnt_nxt;
      ret_cnt         <= ret_cnt_nxt;
      bus.fill_data   <= fill_data_nxt;
      bus.fill_offset <= fill_offset_nxt;
      bus.i_fill_we   <= i_fill_we_nxt;
      bus.d_fill_we   <= d_fill_we_nxt;
      bus.i_done      <= i_done_nxt;
      bus.d_done      <= d_done_nxt;
    end
  end
endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed scoreboard bench for mem_fill_arbiter with a 4-deep pipelined memory model.
module tb_mem_fill_arbiter;
  localparam int WPB = 8;
  localparam int AW  = 16;
  localparam int OW  = 3;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } iss_t;

  typedef struct packed {
    logic        ifw;
    logic        dfw;
    logic [2:0]  off;
    logic [15:0] data;
    logic        idn;
    logic        ddn;
  } fill_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_fill_arbiter_if #(.ADDR_W(AW), .OFF_W(OW)) bus ();
  mem_fill_arbiter #(.WORDS_PER_BLOCK(WPB), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  iss_t        iss_q[$];
  fill_t       fill_q[$];
  logic        pv[4];
  logic [15:0] pd[4];
  logic        force_valid;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int run = 0;
  int max_run = 0;
  int fills_seen = 0;
  int i_done_cyc = -100;
  int wr_cyc = -100;

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  function automatic logic [2:0] exp_start(input logic [15:0] a);
    logic [2:0] s;
`ifdef CRIT_WORD_FIRST_EN
    s = a[3:1];
`else
    s = 3'd0;
`endif
    return s;
  endfunction

  function automatic logic [63:0] all_outs();
    return {bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.fill_data,
            bus.fill_offset, bus.i_fill_we, bus.d_fill_we, bus.i_done, bus.d_done,
            bus.d_wr_ack, bus.busy};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_fill(input logic is_i, input logic [15:0] addr);
    logic [15:0] b, a;
    logic [2:0]  st, off;
    b  = addr & 16'hFFF0;
    st = exp_start(addr);
    for (int k = 0; k < WPB; k++) begin
      off = st + 3'(k);
      a   = b | {12'h000, off, 1'b0};
      iss_q.push_back({1'b0, a, 16'h0000});
      fill_q.push_back({is_i, !is_i, off, mdata(a), is_i && (k == WPB-1), !is_i && (k == WPB-1)});
    end
  endtask

  task automatic push_write(input logic [15:0] addr, input logic [15:0] data);
    iss_q.push_back({1'b1, addr, data});
  endtask

  // One clock: check outputs against the scoreboard, react to done/ack, advance memory.
  task automatic cycle();
    iss_t  e;
    fill_t f;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.i_fill_we || bus.d_fill_we || bus.i_done || bus.d_done) begin
      if (fill_q.size() == 0) begin
        check("unexpected_fill", {bus.i_fill_we, bus.d_fill_we, bus.i_done, bus.d_done}, 64'd0);
      end else begin
        f = fill_q.pop_front();
        check("fill", {bus.i_fill_we, bus.d_fill_we, bus.fill_offset, bus.fill_data, bus.i_done, bus.d_done}, f);
        fills_seen++;
      end
    end
    if (bus.mem_en) begin
      run++;
      if (iss_q.size() == 0) begin
        check("unexpected_issue", {bus.mem_wr, bus.mem_addr}, 64'd0);
      end else begin
        e = iss_q.pop_front();
        check("issue", {bus.mem_wr, bus.d_wr_ack, bus.mem_addr, bus.mem_wdata},
              {e.wr, e.wr, e.addr, e.data});
      end
    end else begin
      run = 0;
      if (bus.mem_wr || bus.d_wr_ack) check("stray_wr", {bus.mem_wr, bus.d_wr_ack}, 64'd0);
    end
    if (run > max_run) max_run = run;
    if (bus.i_done) i_done_cyc = cyc;
    if (bus.mem_wr) wr_cyc = cyc;
    if (bus.i_done) bus.i_req = 1'b0;
    if (bus.d_done) bus.d_req = 1'b0;
    if (bus.d_wr_ack) bus.d_wr_req = 1'b0;
    for (int k = 3; k > 0; k--) begin
      pv[k] = pv[k-1];
      pd[k] = pd[k-1];
    end
    pv[0] = bus.mem_en && !bus.mem_wr;
    pd[0] = mdata(bus.mem_addr);
    bus.mem_valid = pv[3] | force_valid;
    bus.mem_rdata = pv[3] ? pd[3] : 16'hDEAD;
  endtask

  task automatic run_until_empty(input int budget);
    int n = 0;
    while ((fill_q.size() != 0 || iss_q.size() != 0 || bus.busy) && n < budget) begin
      cycle();
      n++;
    end
    check("drain", {fill_q.size() == 0, iss_q.size() == 0}, 64'd3);
  endtask

  initial begin
    int target;
    int n;
    rst = 1'b1;
    force_valid = 1'b0;
    bus.i_req = 1'b0;  bus.i_addr = 16'h0000;
    bus.d_req = 1'b0;  bus.d_addr = 16'h0000;
    bus.d_wr_req = 1'b0; bus.d_wr_addr = 16'h0000; bus.d_wr_data = 16'h0000;
    bus.mem_valid = 1'b0; bus.mem_rdata = 16'h0000;
    for (int k = 0; k < 4; k++) begin pv[k] = 1'b0; pd[k] = 16'h0000; end
    cycle();
    cycle();
    check("reset_outputs", all_outs(), 64'd0);
    rst = 1'b0;
    cycle();
    check("idle_after_reset", all_outs(), 64'd0);

    // Basic icache fill.
    bus.i_addr = 16'h1234; bus.i_req = 1'b1;
    push_fill(1'b1, 16'h1234);
    max_run = 0;
    run_until_empty(100);
    check("t1_burst_len", 64'(max_run), 64'd8);
    cycle();
    check("t1_idle", {bus.busy, bus.i_req}, 64'd0);

    // Write beats dcache fill beats icache fill.
    bus.d_wr_addr = 16'h3002; bus.d_wr_data = 16'hBEEF; bus.d_addr = 16'h0510; bus.i_addr = 16'h0720;
    bus.d_wr_req = 1'b1; bus.d_req = 1'b1; bus.i_req = 1'b1;
    push_write(16'h3002, 16'hBEEF);
    push_fill(1'b0, 16'h0510);
    push_fill(1'b1, 16'h0720);
    run_until_empty(200);
    cycle();

    // Write raised mid-fill waits for the fill and one IDLE cycle.
    bus.i_addr = 16'h0840; bus.i_req = 1'b1;
    push_fill(1'b1, 16'h0840);
    cycle(); cycle(); cycle();
    bus.d_wr_addr = 16'h0902; bus.d_wr_data = 16'h1357; bus.d_wr_req = 1'b1;
    push_write(16'h0902, 16'h1357);
    run_until_empty(100);
    check("t3_wr_after_idle", 64'(wr_cyc - i_done_cyc), 64'd1);
    cycle();

    // Spurious mem_valid while idle.
    force_valid = 1'b1; cycle(); force_valid = 1'b0; cycle(); cycle();
    check("t4_idle_valid", {bus.i_fill_we, bus.d_fill_we, bus.busy}, 64'd0);

    // Extra mem_valid after a full block.
    bus.d_addr = 16'h0A00; bus.d_req = 1'b1;
    push_fill(1'b0, 16'h0A00);
    run_until_empty(100);
    force_valid = 1'b1; cycle(); force_valid = 1'b0; cycle(); cycle();
    check("t4_ninth_valid", {bus.i_fill_we, bus.d_fill_we, bus.busy}, 64'd0);

    // Reset after three returned words aborts the fill.
    bus.i_addr = 16'h0C00; bus.i_req = 1'b1;
    push_fill(1'b1, 16'h0C00);
    target = fills_seen + 3;
    n = 0;
    while (fills_seen < target && n < 100) begin cycle(); n++; end
    check("t5_three_words", 64'(fills_seen >= target), 64'd1);
    rst = 1'b1;
    #1;
    check("t5_reset_async", all_outs(), 64'd0);
    bus.i_req = 1'b0;
    fill_q.delete();
    iss_q.delete();
    cycle(); cycle();
    rst = 1'b0;
    repeat (6) cycle();
    check("t5_late_valid", {bus.i_fill_we, bus.d_fill_we, bus.busy}, 64'd0);
    bus.i_addr = 16'h2200; bus.i_req = 1'b1;
    push_fill(1'b1, 16'h2200);
    run_until_empty(100);
    cycle();

    // Critical-word-first order when enabled, linear order otherwise.
    bus.d_addr = 16'h004A; bus.d_req = 1'b1;
    push_fill(1'b0, 16'h004A);
    run_until_empty(100);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_fill_arbiter.md
Name: mem_fill_arbiter

Overview:
- Shares one pipelined, multi-cycle main memory between the instruction-cache miss path, the data-cache miss path and data-cache write-through.
- Arbitrates among the three requests and sequences each cache-block fill as an 8-word burst.
- Counts issued and returned words and steers returned data into the owning cache.
- Sits between both cache cores and the 4-cycle main-memory model, replacing ad-hoc fill sequencing.

Parameters:
- WORDS_PER_BLOCK, 8, words per cache block; power of two; offset width OFF_W = log2(WORDS_PER_BLOCK).
- ADDR_W, 16, byte address width; words are 16-bit, so word offset = addr[OFF_W:1].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  icache miss request; level, held until i_done.
- i_addr  in  ADDR_W  icache miss byte address.
- d_req  in  1  dcache miss request; level, held until d_done.
- d_addr  in  ADDR_W  dcache miss byte address.
- d_wr_req  in  1  dcache write-through request; held until d_wr_ack.
- d_wr_addr  in  ADDR_W  write byte address.
- d_wr_data  in  16  write data.
- mem_en  out  1  memory access strobe, one word per cycle.
- mem_wr  out  1  memory write.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data.
- mem_valid  in  1  mem_rdata valid; returns in issue order.
- fill_data  out  16  registered returned word.
- fill_offset  out  OFF_W  word index of fill_data within the block.
- i_fill_we  out  1  write fill_data into icache.
- d_fill_we  out  1  write fill_data into dcache.
- i_done  out  1  one-cycle pulse, icache fill complete.
- d_done  out  1  one-cycle pulse, dcache fill complete.
- d_wr_ack  out  1  one-cycle pulse, write issued.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async): state IDLE, issue_cnt = 0, ret_cnt = 0. All outputs 0: mem_en, mem_wr, mem_addr, mem_wdata, fill_*, *_done, d_wr_ack, busy.
- States: IDLE, WRITE, FILL_I, FILL_D.
- IDLE arbitration uses fixed priority d_wr_req > d_req > i_req; the winner is latched the same edge.
  - Winner d_wr_req -> WRITE.
  - Winner d_req or i_req -> FILL_D or FILL_I; latch base = addr with offset bits cleared and start offset = 0.
- WRITE lasts exactly 1 cycle:
  - mem_en = 1, mem_wr = 1, mem_addr = d_wr_addr, mem_wdata = d_wr_data, d_wr_ack = 1.
  - Next state IDLE.
- FILL_x issue phase:
  - mem_en = 1, mem_wr = 0, mem_addr = base | (issue_offset << 1).
  - issue_cnt increments each cycle until it reaches WORDS_PER_BLOCK; then mem_en = 0.
  - issue_offset = (start + issue_cnt) mod WORDS_PER_BLOCK.
- FILL_x return phase, overlapping the issue phase:
  - Each cycle with mem_valid: next cycle fill_data = mem_rdata, fill_offset = (start + ret_cnt) mod WORDS_PER_BLOCK, x_fill_we = 1, and ret_cnt increments.
  - The other cache's fill_we stays 0.
- Completion: the cycle that presents the WORDS_PER_BLOCK-th word also asserts x_done, and the state returns to IDLE on that edge. Back-to-back grants are therefore possible with one IDLE cycle between them.
- Requests arriving during a fill are held off; a pending write waits for fill completion.
- A request dropped mid-fill is ignored; the fill completes.
- mem_valid in IDLE or WRITE, or after ret_cnt is full, is ignored: no fill_we, no counter change.
- Reset mid-fill aborts immediately; late mem_valid after reset is ignored.
- Counters are OFF_W+1 bits and never wrap within a fill; offset arithmetic wraps mod WORDS_PER_BLOCK.

Optional Feature:
- Macro CRIT_WORD_FIRST_EN.
  - Defined: at grant, start = the requester's addr[OFF_W:1]. Issue and fill_offset begin at the missed word and wrap around the block (e.g. 5,6,7,0,1,2,3,4).
  - Undefined: start is always 0 and the requester's low address bits are ignored.

Test Plan:
- Reset, then i_req=1 with i_addr=0x1234 held; memory latency 4 -> mem_addr 0x1230,0x1232,…,0x123E on 8 consecutive cycles. i_fill_we with fill_offset 0..7 follows; i_done coincides with offset 7; d_fill_we stays 0 throughout.
- d_wr_req, d_req and i_req all asserted in IDLE -> first a 1-cycle WRITE with d_wr_ack=1, mem_wr=1 and d_wr_addr/d_wr_data on the bus. Then the D fill completes (d_done), then the I fill.
- d_wr_req raised during the 3rd cycle of an I fill -> no mem_wr until the cycle after i_done passes through IDLE; i_fill data is undisturbed.
- Spurious mem_valid while in IDLE, and a 9th mem_valid after the block is full -> no fill_we, counters unchanged.
- rst pulsed mid-fill after 3 returned words -> outputs 0 immediately. Later mem_valid produces nothing; a new i_req restarts at offset 0.
- With CRIT_WORD_FIRST_EN defined, d_req at d_addr=0x004A -> issue order 0x004A,0x004C,0x004E,0x0040,…,0x0048. fill_offset runs 5,6,7,0,1,2,3,4; d_done coincides with offset 4.
